// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch through.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } state_t;

  state_t        state;
  logic [CW-1:0] scnt;
  logic          dreq;

  assign dreq = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      scnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iREN && scnt == LIM) state <= IACC;
          else if (dreq)           state <= DACC;
          else if (iREN)           state <= IACC;
        end
        IACC: begin
          if (ram_ready) begin
            state <= IDLE;
            scnt  <= '0;
          end
        end
        DACC: begin
          if (ram_ready) begin
            state <= IDLE;
            if (!iREN)
              scnt <= '0;
            else if (scnt != LIM)
              scnt <= scnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from the async-reset state, so reset drops them at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    case (state)
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        ihit    = ram_ready;
        if (ram_ready) iload = ramload;
      end
      DACC: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dhit     = ram_ready;
        if (ram_ready && dREN && !dWEN) dload = ramload;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run
// against a cycle-level model built from the arbitration rules.
module tb_mem_arbiter;

  localparam int LIM = 4;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ramREN, ramWEN, ihit, dhit;
  logic [31:0] ramaddr, ramstore, iload, dload;

  int checks = 0;
  int errors = 0;
  logic [131:0] exp_v;

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ihit(ihit), .dhit(dhit),
    .iload(iload), .dload(dload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [131:0] outv();
    return {ramREN, ramWEN, ramaddr, ramstore,
            ihit, dhit, iload, dload};
  endfunction

  function automatic logic [131:0] ev(
    input logic r, input logic w,
    input logic [31:0] a, input logic [31:0] s,
    input logic ih, input logic dh,
    input logic [31:0] il, input logic [31:0] dl);
    return {r, w, a, s, ih, dh, il, dl};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
  endtask

  task automatic test_reset();
    nRST = 0;
    clear_inputs();
    #2;
    checks++;
    if (outv() !== '0) begin
      errors++;
      $display("FAIL reset_outs got %h exp 0", outv());
    end
    iREN = 1; ram_ready = 1;
    tick();
    @(negedge CLK);
    checks++;
    if (outv() !== '0) begin
      errors++;
      $display("FAIL reset_hold got %h exp 0", outv());
    end
    tick();
    clear_inputs();
    nRST = 1;
  endtask

  task automatic test_spurious_ready();
    for (int c = 0; c < 3; c++) begin
      ram_ready = 1; ramload = 32'hFFFF_0000 + c;
      @(negedge CLK);
      checks++;
      if (outv() !== '0) begin
        errors++;
        $display("FAIL spurious_%0d got %h exp 0", c, outv());
      end
      tick();
    end
    ram_ready = 0; ramload = 0;
  endtask

  task automatic test_lone_fetch();
    iREN = 1; iaddr = 32'h40;
    tick();
    for (int c = 0; c < 3; c++) begin
      ram_ready = (c == 2);
      ramload = (c == 2) ? 32'h8C22_0004 : 32'h1111_1111;
      @(negedge CLK);
      exp_v = ev(1, 0, 32'h40, 0, c == 2, 0,
                 (c == 2) ? 32'h8C22_0004 : 32'h0, 0);
      checks++;
      if (outv() !== exp_v) begin
        errors++;
        $display("FAIL fetch_c%0d got %h exp %h", c, outv(), exp_v);
      end
      tick();
    end
    clear_inputs();
    @(negedge CLK);
    checks++;
    if (outv() !== '0) begin
      errors++;
      $display("FAIL fetch_idle got %h exp 0", outv());
    end
    tick();
  endtask

  task automatic test_write_priority();
    dREN = 1; dWEN = 1;
    daddr = 32'h200; dstore = 32'hDEAD_BEEF;
    tick();
    @(negedge CLK);
    exp_v = ev(0, 1, 32'h200, 32'hDEAD_BEEF, 0, 0, 0, 0);
    checks++;
    if (outv() !== exp_v) begin
      errors++;
      $display("FAIL wr_strobe got %h exp %h", outv(), exp_v);
    end
    tick();
    ram_ready = 1; ramload = 32'h1234_5678;
    @(negedge CLK);
    exp_v = ev(0, 1, 32'h200, 32'hDEAD_BEEF, 0, 1, 0, 0);
    checks++;
    if (outv() !== exp_v) begin
      errors++;
      $display("FAIL wr_hit got %h exp %h", outv(), exp_v);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_simultaneous();
    iREN = 1; iaddr = 32'h44;
    dREN = 1; daddr = 32'h100;
    tick();
    ram_ready = 1; ramload = 32'hAAAA_0001;
    @(negedge CLK);
    exp_v = ev(1, 0, 32'h100, 0, 0, 1, 0, 32'hAAAA_0001);
    checks++;
    if (outv() !== exp_v) begin
      errors++;
      $display("FAIL sim_data got %h exp %h", outv(), exp_v);
    end
    tick();
    dREN = 0; daddr = 0;
    @(negedge CLK);
    checks++;
    if (outv() !== '0) begin
      errors++;
      $display("FAIL sim_bubble got %h exp 0", outv());
    end
    tick();
    ramload = 32'hBBBB_0002;
    @(negedge CLK);
    exp_v = ev(1, 0, 32'h44, 0, 1, 0, 32'hBBBB_0002, 0);
    checks++;
    if (outv() !== exp_v) begin
      errors++;
      $display("FAIL sim_instr got %h exp %h", outv(), exp_v);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_starvation();
    int dcnt;
    bit got;
    iREN = 1; iaddr = 32'h80;
    dREN = 1; daddr = 32'h400;
    ram_ready = 1;
    for (int r = 0; r < 2; r++) begin
      dcnt = 0; got = 0;
      for (int c = 0; c < 30 && !got; c++) begin
        ramload = 32'hC000_0000 + c;
        @(negedge CLK);
        if (dhit) dcnt++;
        if (ihit) got = 1;
        tick();
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL starve_r%0d_ihit got none exp 1", r);
      end
      checks++;
      if (dcnt != LIM) begin
        errors++;
        $display("FAIL starve_r%0d_count got %0d exp %0d", r, dcnt, LIM);
      end
    end
    iREN = 0;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    checks++;
    if (dhit !== 1'b1) begin
      errors++;
      $display("FAIL starve_resume got %b exp 1", dhit);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_access();
    dWEN = 1; daddr = 32'h300; dstore = 32'h55;
    tick();
    @(negedge CLK);
    exp_v = ev(0, 1, 32'h300, 32'h55, 0, 0, 0, 0);
    checks++;
    if (outv() !== exp_v) begin
      errors++;
      $display("FAIL rst_mid_pre got %h exp %h", outv(), exp_v);
    end
    #2;
    nRST = 0;
    #1;
    checks++;
    if (outv() !== '0) begin
      errors++;
      $display("FAIL rst_mid_async got %h exp 0", outv());
    end
    dWEN = 0; ram_ready = 1;
    tick();
    tick();
    nRST = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      checks++;
      if (outv() !== '0) begin
        errors++;
        $display("FAIL rst_mid_after%0d got %h exp 0", c, outv());
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int mst, msc, op;
    bit ipend, dpend, ih_seen, dh_seen;
    logic r, w, ih, dh;
    logic [31:0] a, s, il, dl;
    clear_inputs();
    nRST = 0;
    #2;
    nRST = 1;
    tick();
    mst = 0; msc = 0;
    ipend = 0; dpend = 0; ih_seen = 0; dh_seen = 0;
    for (int c = 0; c < 2000; c++) begin
      if (ih_seen) ipend = 0;
      if (dh_seen) dpend = 0;
      if (!ipend && $urandom_range(0, 2) != 0) begin
        ipend = 1;
        iaddr = $urandom;
      end
      iREN = ipend;
      if (!dpend && $urandom_range(0, 2) != 0) begin
        dpend = 1;
        op = $urandom_range(0, 2);
        dREN = (op != 1);
        dWEN = (op != 0);
        daddr = $urandom;
        dstore = $urandom;
      end
      if (!dpend) begin
        dREN = 0; dWEN = 0;
      end
      ram_ready = ($urandom_range(0, 9) < 4);
      ramload = $urandom;
      @(negedge CLK);
      r = 0; w = 0; a = 0; s = 0;
      ih = 0; dh = 0; il = 0; dl = 0;
      if (mst == 1) begin
        r = 1; a = iaddr; ih = ram_ready;
        il = ram_ready ? ramload : 0;
      end else if (mst == 2) begin
        w = dWEN; r = dREN && !dWEN;
        a = daddr; s = dstore; dh = ram_ready;
        dl = (ram_ready && dREN && !dWEN) ? ramload : 0;
      end
      exp_v = ev(r, w, a, s, ih, dh, il, dl);
      checks++;
      if (outv() !== exp_v) begin
        errors++;
        $display("FAIL rand_c%0d got %h exp %h", c, outv(), exp_v);
      end
      ih_seen = ih;
      dh_seen = dh;
      if (mst == 0) begin
        if (iREN && msc == LIM) mst = 1;
        else if (dREN || dWEN)  mst = 2;
        else if (iREN)          mst = 1;
      end else if (ram_ready) begin
        if (mst == 1 || !iREN) msc = 0;
        else if (msc < LIM)    msc = msc + 1;
        mst = 0;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    tick();
    test_spurious_ready();
    test_lone_fetch();
    test_write_priority();
    test_simultaneous();
    test_starvation();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
